// File: rtl/userdma_ctrl_seq.sv
// Command sequencer for the userdma kernel in ap_ctrl_chain mode.
// It validates one command, drives the kernel handshake and returns one status record.
module userdma_ctrl_seq #(
  parameter int unsigned      ADDR_W         = 64,
  parameter int unsigned      LEN_W          = 32,
  parameter logic [LEN_W-1:0] MAX_LEN        = LEN_W'(32'h0010_0000),
  parameter logic [31:0]      TIMEOUT_CYCLES = 32'h0010_0000
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_mode,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [ADDR_W-1:0] cmd_s2m_addr,
  input  logic [ADDR_W-1:0] cmd_m2s_addr,
  output logic              k_ap_start,
  input  logic              k_ap_ready,
  input  logic              k_ap_done,
  input  logic              k_ap_idle,
  output logic              k_ap_continue,
  output logic [1:0]        k_kernel_mode,
  output logic [ADDR_W-1:0] k_s2m_buf,
  output logic [ADDR_W-1:0] k_m2s_buf,
  output logic [LEN_W-1:0]  k_len,
  output logic              sts_valid,
  input  logic              sts_ready,
  output logic [1:0]        sts_code,
  output logic [31:0]       sts_cycles
);

  typedef enum logic [2:0] {IDLE, LAUNCH, RUN, ACK, REPORT} state_e;

  state_e            state_q, state_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [31:0]       cycles_q, cycles_d;
  logic [1:0]        code_q, code_d;
  logic [1:0]        mode_q, mode_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [ADDR_W-1:0] s2mBuf_q, s2mBuf_d;
  logic [ADDR_W-1:0] m2sBuf_q, m2sBuf_d;
  logic              staleCont_q, staleCont_d;
  logic              cmdAccept;
  logic              cmdBad;
  logic              timeout;
  logic [31:0]       cntInc;

  assign cmd_ready     = (state_q == IDLE) & k_ap_idle & ap_rst_n;
  assign k_ap_start    = (state_q == LAUNCH);
  assign k_ap_continue = (state_q == ACK) | staleCont_q;
  assign sts_valid     = (state_q == REPORT);
  assign sts_code      = code_q;
  assign sts_cycles    = cycles_q;
  assign k_kernel_mode = mode_q;
  assign k_len         = len_q;
  assign k_s2m_buf     = s2mBuf_q;
  assign k_m2s_buf     = m2sBuf_q;

  always_comb begin
    cmdAccept = cmd_valid & cmd_ready;
    cmdBad    = (cmd_mode == 2'b00) | (cmd_len == '0) | (cmd_len > MAX_LEN) |
                (cmd_mode[0] & (|cmd_s2m_addr[5:0])) |
                (cmd_mode[1] & (|cmd_m2s_addr[5:0]));
    // cntInc is the count including the current LAUNCH/RUN cycle
    cntInc    = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
    timeout   = (cntInc == TIMEOUT_CYCLES);

    state_d   = state_q;
    cnt_d     = cnt_q;
    cycles_d  = cycles_q;
    code_d    = code_q;
    mode_d    = mode_q;
    len_d     = len_q;
    s2mBuf_d  = s2mBuf_q;
    m2sBuf_d  = m2sBuf_q;
    // a done outside a live command belongs to a kernel we already gave up on
    staleCont_d = ((state_q == IDLE) | (state_q == REPORT)) & k_ap_done & ~k_ap_continue;

    case (state_q)
      IDLE: begin
        if (cmdAccept) begin
          mode_d   = cmd_mode;
          len_d    = cmd_len;
          s2mBuf_d = cmd_s2m_addr;
          m2sBuf_d = cmd_m2s_addr;
          if (cmdBad) begin
            state_d  = REPORT;
            code_d   = 2'b10;
            cycles_d = 32'd0;
          end else begin
            state_d = LAUNCH;
            cnt_d   = 32'd0;
          end
        end
      end
      LAUNCH: begin
        cnt_d = cntInc;
        if (timeout) begin
          state_d  = REPORT;
          code_d   = 2'b01;
          cycles_d = TIMEOUT_CYCLES;
        end else if (k_ap_ready & k_ap_done) begin
          state_d  = ACK;
          code_d   = 2'b00;
          cycles_d = cntInc;
        end else if (k_ap_ready) begin
          state_d = RUN;
        end
      end
      RUN: begin
        cnt_d = cntInc;
        if (timeout) begin
          state_d  = REPORT;
          code_d   = 2'b01;
          cycles_d = TIMEOUT_CYCLES;
        end else if (k_ap_done) begin
          state_d  = ACK;
          code_d   = 2'b00;
          cycles_d = cntInc;
        end
      end
      ACK: begin
        state_d = REPORT;
      end
      REPORT: begin
        if (sts_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 32'd0;
      cycles_q    <= 32'd0;
      code_q      <= 2'b00;
      mode_q      <= 2'b00;
      len_q       <= '0;
      s2mBuf_q    <= '0;
      m2sBuf_q    <= '0;
      staleCont_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cycles_q    <= cycles_d;
      code_q      <= code_d;
      mode_q      <= mode_d;
      len_q       <= len_d;
      s2mBuf_q    <= s2mBuf_d;
      m2sBuf_q    <= m2sBuf_d;
      staleCont_q <= staleCont_d;
    end
  end

endmodule
